slv_axi4_id_remap: RTL and testbench
====================================

# slv_axi4_id_remap

Slave-side AXI4 ID remapper for one address/response channel pair (AR/R, or AW/B with LAST tied high). It sits between the interconnect's internal slave port and a slave whose ID width is narrower than the interconnect ID. Internal IDs are translated to a pool of 2**SLV_ID_WIDTH tags, and the original ID is restored on responses. This generalises the single-FIFO zero-ID scheme: slave-side read interleaving across tags is allowed, and same-ID ordering is still preserved.

## Interface
- MST_ID_WIDTH, 4: internal (interconnect) ID width, 1–8.
- SLV_ID_WIDTH, 2: slave ID width, 1–4. NUM_TAGS = 2**SLV_ID_WIDTH.
- CNT_WIDTH, 3: per-tag outstanding counter width. Maximum outstanding transactions per tag is 2**CNT_WIDTH-1.
- ACLK  in  1  clock, rising edge.
- sysReset  in  1  asynchronous, active-high reset.
- int_slaveAID  in  MST_ID_WIDTH  internal address ID.
- int_slaveAVALID  in  1  internal address valid.
- int_slaveAREADY  out  1  internal address ready.
- SLAVE_AID  out  SLV_ID_WIDTH  allocated tag.
- SLAVE_AVALID  out  1  slave address valid.
- SLAVE_AREADY  in  1  slave address ready.
- SLAVE_ID  in  SLV_ID_WIDTH  response tag.
- SLAVE_VALID  in  1  response valid.
- SLAVE_LAST  in  1  response last beat. Tie to 1 for the B channel.
- SLAVE_READY  out  1  response ready.
- int_slaveID  out  MST_ID_WIDTH  restored internal ID.
- int_slaveVALID  out  1  internal response valid.
- int_slaveLAST  out  1  internal response last.
- int_slaveREADY  in  1  internal response ready.
- unexpRespErr  out  1  sticky flag: a response arrived for a tag with zero outstanding transactions.

## Operation
- Each tag t holds storedId[t] (MST_ID_WIDTH) and cnt[t] (CNT_WIDTH). A tag is busy when cnt[t] != 0.
- Hit: int_slaveAID equals storedId[t] on a busy tag t. At most one tag can hit, by construction.
- Allocation, evaluated each cycle from registered state plus int_slaveAID:
  - On a hit, selTag = t and canAccept = (cnt[t] != max). Reusing the tag keeps same-ID responses ordered.
  - On a miss, selTag = the lowest-index free tag and canAccept = (any tag free).
- Address path, combinational:
  - SLAVE_AID = selTag.
  - SLAVE_AVALID = int_slaveAVALID & canAccept.
  - int_slaveAREADY = SLAVE_AREADY & canAccept.
  - SLAVE_AVALID must not depend on SLAVE_AREADY.
- Address handshake (SLAVE_AVALID & SLAVE_AREADY): cnt[selTag] increments. On a miss, storedId[selTag] is also loaded with int_slaveAID.
- Response path, combinational:
  - int_slaveID = storedId[SLAVE_ID].
  - int_slaveVALID = SLAVE_VALID.
  - int_slaveLAST = SLAVE_LAST.
  - SLAVE_READY = int_slaveREADY.
- Response retire (SLAVE_VALID & SLAVE_READY & SLAVE_LAST): cnt[SLAVE_ID] decrements. When cnt reaches 0 the tag is free on the next cycle.
- Retire on a tag whose cnt is 0: the counter does not change (no underflow), unexpRespErr sets to 1 and stays set until reset, and the beat is still forwarded.
- Same-cycle increment and retire:
  - Same tag: cnt is unchanged. storedId is not reloaded, because the address is a hit.
  - Different tags: both updates apply.
- A tag freed this cycle is not allocatable until the next cycle. Allocation uses registered cnt only.

## Timing
- Address and response paths have zero latency (combinational). Table updates take effect at the rising edge after the handshake.
- Reset (asynchronous assert, sampled deassert): all cnt = 0, storedId = 0, unexpRespErr = 0.
  - Combinational outputs then follow their inputs with an empty table: SLAVE_AID = 0 and canAccept = 1.
- Reset mid-transaction discards all outstanding state. Slave and master are reset together by system rule.
- Full condition:
  - With all tags busy on other IDs, a new ID stalls with SLAVE_AVALID = 0 until any tag retires.
  - A hit on a tag at max count stalls in the same way.

## Structure
- Shared package slv_axi4_id_remap_pkg:
  - NUM_TAGS derivation.
  - Lowest-set-bit priority-encoder function used for the free-tag search.
- Sub-module slv_axi4_id_tag_entry, one instance per tag:
  - Holds storedId and cnt.
  - Inputs: load, inc, dec.
  - Outputs: busy, atMax, the match result against the incoming ID, and errOnDec.
- The top level holds the selection logic, the response mux and the error flag.

## Test plan
1. Single transaction. Reset, then AID=0xA, 4-beat read with LAST on beat 4 → SLAVE_AID=0; int_slaveID=0xA on all beats; cnt[0] returns to 0; tag 0 is free.
2. Same-ID reuse. AIDs 0x3, 0x3, 0x5 back-to-back → tags 0, 0, 1; cnt[0]=2 and cnt[1]=1 after the third handshake.
3. Pool exhaustion (SLV_ID_WIDTH=2). Issue IDs 1, 2, 3, 4, then ID 5 → ID 5 sees SLAVE_AVALID=0. Retire tag 2 → ID 5 is accepted on tag 2 the following cycle.
4. Counter saturation (CNT_WIDTH=3). Issue 7 transactions with ID 0x6 → the 8th stalls. One retire → the 8th is accepted one cycle later.
5. Simultaneous events:
   - Hit on tag 1 in the same cycle as a retire on tag 1 → cnt[1] unchanged.
   - Hit on tag 0 in the same cycle as a retire on tag 2 → both counters update.
6. Errors and reset:
   - Response on idle tag 3 → beat is forwarded, unexpRespErr=1 and stays set.
   - Assert sysReset mid-burst → all counters clear and the flag clears immediately.

Source files
------------

// File: rtl/slv_axi4_id_remap_pkg.sv
// -----------------------------------------------------------------------------
// slv_axi4_id_remap_pkg
//   Shared definitions for the slave-side AXI4 ID remapper:
//     - MAX_TAGS / TAG_IDX_W : upper bound on the tag pool (SLV_ID_WIDTH <= 4)
//     - num_tags()           : tag pool size derived from the slave ID width
//     - lowest_set_idx()     : lowest-set-bit priority encoder, used both for
//                              the free-tag search and for encoding the
//                              one-hot hit vector
// -----------------------------------------------------------------------------
package slv_axi4_id_remap_pkg;

    localparam int MAX_TAGS  = 16;
    localparam int TAG_IDX_W = 4;

    function automatic int num_tags(input int slv_id_width);
        return 1 << slv_id_width;
    endfunction

    // Returns the index of the lowest set bit, or 0 when no bit is set.
    // Callers qualify the result with their own "any bit set" term.
    function automatic logic [TAG_IDX_W-1:0] lowest_set_idx(input logic [MAX_TAGS-1:0] vec);
        logic [TAG_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_TAGS - 1; i >= 0; i--) begin
            if (vec[i]) idx = TAG_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/slv_axi4_id_tag_entry.sv
// -----------------------------------------------------------------------------
// slv_axi4_id_tag_entry
//   One entry of the remap table: the internal ID bound to a tag and the
//   number of transactions outstanding on it.
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     load_i, id_i      bind id_i to this tag (address handshake on a miss)
//     inc_i             address handshake on this tag
//     dec_i             last response beat retired on this tag
//     busy_o            count non-zero
//     at_max_o          count saturated, no further transactions accepted
//     match_o           busy and bound ID equals id_i
//     err_on_dec_o      dec_i while the count is zero
//     stored_id_o       bound internal ID, for the response mux
// -----------------------------------------------------------------------------
module slv_axi4_id_tag_entry #(
    parameter int MST_ID_WIDTH = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic [MST_ID_WIDTH-1:0] id_i,
    input  logic                    inc_i,
    input  logic                    dec_i,
    output logic                    busy_o,
    output logic                    at_max_o,
    output logic                    match_o,
    output logic                    err_on_dec_o,
    output logic [MST_ID_WIDTH-1:0] stored_id_o
);

    logic [MST_ID_WIDTH-1:0] stored_id_q, stored_id_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    dec_ok;

    assign busy_o       = (cnt_q != '0);
    assign at_max_o     = (cnt_q == '1);
    assign match_o      = busy_o && (stored_id_q == id_i);
    assign err_on_dec_o = dec_i && !busy_o;
    assign stored_id_o  = stored_id_q;

    // A retire on an idle tag is flagged upstream and never underflows.
    assign dec_ok = dec_i && busy_o;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the ifs can leave it unassigned and infer a latch.
        cnt_d       = cnt_q;
        stored_id_d = stored_id_q;
        if (inc_i && !dec_ok) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (!inc_i && dec_ok) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
        if (load_i) begin
            stored_id_d = id_i;
        end
    end

    // NOTE: the bound ID is reset along with the count; it is a handful of
    // flops, and a defined value keeps the response mux output deterministic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            cnt_q       <= '0;
            stored_id_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stored_id_q <= stored_id_d;
        end
    end

endmodule

// File: rtl/slv_axi4_id_remap.sv
// -----------------------------------------------------------------------------
// slv_axi4_id_remap
//   Slave-side AXI4 ID remapper for one address/response channel pair.
//   Wide internal IDs are mapped onto 2**SLV_ID_WIDTH slave tags; the original
//   ID is restored on responses. Transactions with the same internal ID always
//   share a tag, so the slave keeps them in order.
//   Ports:
//     ACLK, sysReset                  clock, asynchronous active-high reset
//     int_slaveAID/AVALID/AREADY      internal address channel
//     SLAVE_AID/AVALID/AREADY         slave address channel (tag as ID)
//     SLAVE_ID/VALID/LAST/READY       slave response channel
//     int_slaveID/VALID/LAST/READY    internal response channel (restored ID)
//     unexpRespErr                    sticky: response on a tag with nothing
//                                     outstanding
// -----------------------------------------------------------------------------
module slv_axi4_id_remap
    import slv_axi4_id_remap_pkg::*;
#(
    parameter int MST_ID_WIDTH = 4,
    parameter int SLV_ID_WIDTH = 2,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                    ACLK,
    input  logic                    sysReset,
    input  logic [MST_ID_WIDTH-1:0] int_slaveAID,
    input  logic                    int_slaveAVALID,
    output logic                    int_slaveAREADY,
    output logic [SLV_ID_WIDTH-1:0] SLAVE_AID,
    output logic                    SLAVE_AVALID,
    input  logic                    SLAVE_AREADY,
    input  logic [SLV_ID_WIDTH-1:0] SLAVE_ID,
    input  logic                    SLAVE_VALID,
    input  logic                    SLAVE_LAST,
    output logic                    SLAVE_READY,
    output logic [MST_ID_WIDTH-1:0] int_slaveID,
    output logic                    int_slaveVALID,
    output logic                    int_slaveLAST,
    input  logic                    int_slaveREADY,
    output logic                    unexpRespErr
);

    localparam int NUM_TAGS = num_tags(SLV_ID_WIDTH);

    logic [NUM_TAGS-1:0]     busy, at_max, match, err_on_dec;
    logic [NUM_TAGS-1:0]     inc, dec, load;
    logic [MST_ID_WIDTH-1:0] stored_id [NUM_TAGS];

    logic                    hit;
    logic [SLV_ID_WIDTH-1:0] hit_idx, free_idx, sel_tag;
    logic                    can_accept;
    logic                    addr_hs, retire;
    logic                    err_q, err_d;

    // Tag selection uses registered table state only, so a tag freed this
    // cycle becomes allocatable on the next one.
    always_comb begin
        hit        = |match;
        hit_idx    = SLV_ID_WIDTH'(lowest_set_idx(MAX_TAGS'(match)));
        free_idx   = SLV_ID_WIDTH'(lowest_set_idx(MAX_TAGS'(~busy)));
        sel_tag    = hit ? hit_idx : free_idx;
        can_accept = hit ? !at_max[hit_idx] : !(&busy);
    end

    // SLAVE_AVALID is deliberately independent of SLAVE_AREADY.
    assign SLAVE_AID       = sel_tag;
    assign SLAVE_AVALID    = int_slaveAVALID & can_accept;
    assign int_slaveAREADY = SLAVE_AREADY & can_accept;
    assign addr_hs         = SLAVE_AVALID & SLAVE_AREADY;

    assign int_slaveID    = stored_id[SLAVE_ID];
    assign int_slaveVALID = SLAVE_VALID;
    assign int_slaveLAST  = SLAVE_LAST;
    assign SLAVE_READY    = int_slaveREADY;
    assign retire         = SLAVE_VALID & int_slaveREADY & SLAVE_LAST;

    for (genvar t = 0; t < NUM_TAGS; t++) begin : g_tag
        assign inc[t]  = addr_hs && (sel_tag == SLV_ID_WIDTH'(t));
        assign load[t] = inc[t] && !hit;
        assign dec[t]  = retire && (SLAVE_ID == SLV_ID_WIDTH'(t));

        slv_axi4_id_tag_entry #(
            .MST_ID_WIDTH (MST_ID_WIDTH),
            .CNT_WIDTH    (CNT_WIDTH)
        ) u_entry (
            .clk_i        (ACLK),
            .rst_i        (sysReset),
            .load_i       (load[t]),
            .id_i         (int_slaveAID),
            .inc_i        (inc[t]),
            .dec_i        (dec[t]),
            .busy_o       (busy[t]),
            .at_max_o     (at_max[t]),
            .match_o      (match[t]),
            .err_on_dec_o (err_on_dec[t]),
            .stored_id_o  (stored_id[t])
        );
    end

    assign err_d        = err_q | (|err_on_dec);
    assign unexpRespErr = err_q;

    always_ff @(posedge ACLK or posedge sysReset) begin
        if (sysReset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_slv_axi4_id_remap.sv
// -----------------------------------------------------------------------------
// tb_slv_axi4_id_remap
//   Self-checking bench: directed scenarios followed by randomized traffic,
//   compared every cycle against a table-level model of the remapper.
// -----------------------------------------------------------------------------
module tb_slv_axi4_id_remap;

    localparam int MW      = 4;
    localparam int SW      = 2;
    localparam int CW      = 3;
    localparam int NT      = 1 << SW;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          ACLK;
    logic          sysReset;
    logic [MW-1:0] int_slaveAID;
    logic          int_slaveAVALID;
    logic          int_slaveAREADY;
    logic [SW-1:0] SLAVE_AID;
    logic          SLAVE_AVALID;
    logic          SLAVE_AREADY;
    logic [SW-1:0] SLAVE_ID;
    logic          SLAVE_VALID;
    logic          SLAVE_LAST;
    logic          SLAVE_READY;
    logic [MW-1:0] int_slaveID;
    logic          int_slaveVALID;
    logic          int_slaveLAST;
    logic          int_slaveREADY;
    logic          unexpRespErr;

    slv_axi4_id_remap #(
        .MST_ID_WIDTH (MW),
        .SLV_ID_WIDTH (SW),
        .CNT_WIDTH    (CW)
    ) dut (
        .ACLK            (ACLK),
        .sysReset        (sysReset),
        .int_slaveAID    (int_slaveAID),
        .int_slaveAVALID (int_slaveAVALID),
        .int_slaveAREADY (int_slaveAREADY),
        .SLAVE_AID       (SLAVE_AID),
        .SLAVE_AVALID    (SLAVE_AVALID),
        .SLAVE_AREADY    (SLAVE_AREADY),
        .SLAVE_ID        (SLAVE_ID),
        .SLAVE_VALID     (SLAVE_VALID),
        .SLAVE_LAST      (SLAVE_LAST),
        .SLAVE_READY     (SLAVE_READY),
        .int_slaveID     (int_slaveID),
        .int_slaveVALID  (int_slaveVALID),
        .int_slaveLAST   (int_slaveLAST),
        .int_slaveREADY  (int_slaveREADY),
        .unexpRespErr    (unexpRespErr)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: per-tag outstanding count and bound ID, plus error flag.
    int          m_cnt [NT];
    logic [MW-1:0] m_id [NT];
    bit          m_err;

    // Decision computed at the compare point, consumed at the clock edge.
    int c_sel;
    bit c_hit;
    bit c_can;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int t = 0; t < NT; t++) begin
            m_cnt[t] = 0;
            m_id[t]  = '0;
        end
        m_err = 1'b0;
    endtask

    // Computes the expected allocation decision and checks every output.
    task automatic compare_outputs();
        int free_t;
        bit any_free;
        if (sysReset) reset_model();
        c_hit    = 1'b0;
        c_sel    = 0;
        any_free = 1'b0;
        free_t   = 0;
        for (int t = 0; t < NT; t++) begin
            if (m_cnt[t] > 0 && m_id[t] == int_slaveAID) begin
                c_hit = 1'b1;
                c_sel = t;
            end
            if (m_cnt[t] == 0 && !any_free) begin
                any_free = 1'b1;
                free_t   = t;
            end
        end
        if (!c_hit) c_sel = free_t;
        c_can = c_hit ? (m_cnt[c_sel] < CNT_MAX) : any_free;

        if (c_can) check("slave_aid", SLAVE_AID, c_sel);
        check("slave_avalid", SLAVE_AVALID, int_slaveAVALID && c_can);
        check("int_aready", int_slaveAREADY, SLAVE_AREADY && c_can);
        check("int_rid", int_slaveID, m_id[SLAVE_ID]);
        check("int_rvalid", int_slaveVALID, SLAVE_VALID);
        check("int_rlast", int_slaveLAST, SLAVE_LAST);
        check("slave_rready", SLAVE_READY, int_slaveREADY);
        check("unexp_err", unexpRespErr, m_err);
    endtask

    task automatic update_model();
        bit hs, ret, inc, dec;
        if (sysReset) begin
            reset_model();
            return;
        end
        hs  = int_slaveAVALID && SLAVE_AREADY && c_can;
        ret = SLAVE_VALID && int_slaveREADY && SLAVE_LAST;
        if (ret && m_cnt[SLAVE_ID] == 0) m_err = 1'b1;
        for (int t = 0; t < NT; t++) begin
            inc = hs && (c_sel == t);
            dec = ret && (SLAVE_ID == t) && (m_cnt[t] > 0);
            if (inc && !c_hit) m_id[t] = int_slaveAID;
            m_cnt[t] = m_cnt[t] + int'(inc) - int'(dec);
        end
    endtask

    // One clock: compare mid-cycle, advance the model at the edge, then
    // return just after the edge so the caller can drive the next inputs.
    task automatic step();
        @(negedge ACLK);
        compare_outputs();
        @(posedge ACLK);
        update_model();
        #1;
    endtask

    task automatic idle_inputs();
        int_slaveAVALID = 1'b0;
        SLAVE_VALID     = 1'b0;
        SLAVE_LAST      = 1'b0;
    endtask

    task automatic addr(input logic [MW-1:0] id);
        idle_inputs();
        int_slaveAID    = id;
        int_slaveAVALID = 1'b1;
        #1;
    endtask

    task automatic resp(input int tag, input bit last);
        idle_inputs();
        SLAVE_ID    = SW'(tag);
        SLAVE_VALID = 1'b1;
        SLAVE_LAST  = last;
        #1;
    endtask

    initial begin
        int busy_list [$];
        int pick;

        sysReset        = 1'b1;
        int_slaveAID    = '0;
        int_slaveAVALID = 1'b0;
        SLAVE_AREADY    = 1'b1;
        SLAVE_ID        = '0;
        SLAVE_VALID     = 1'b0;
        SLAVE_LAST      = 1'b0;
        int_slaveREADY  = 1'b1;
        reset_model();
        repeat (2) @(posedge ACLK);
        #1;
        sysReset = 1'b0;

        // Reset state: empty table, tag 0 offered, flag clear.
        #1;
        check("rst_err", unexpRespErr, 0);
        check("rst_aid", SLAVE_AID, 0);
        check("rst_aready", int_slaveAREADY, 1);

        // 1: single 4-beat read on ID 0xA.
        addr(4'hA);
        check("t1_aid", SLAVE_AID, 0);
        check("t1_avalid", SLAVE_AVALID, 1);
        step();
        for (int b = 0; b < 4; b++) begin
            resp(0, b == 3);
            check("t1_rid", int_slaveID, 4'hA);
            step();
        end
        check("t1_cnt0_model", m_cnt[0], 0);
        addr(4'h7);
        check("t1_tag0_free", SLAVE_AID, 0);
        idle_inputs();
        step();

        // 2: same-ID reuse.
        addr(4'h3); check("t2_aid_a", SLAVE_AID, 0); step();
        addr(4'h3); check("t2_aid_b", SLAVE_AID, 0); step();
        addr(4'h5); check("t2_aid_c", SLAVE_AID, 1); step();
        check("t2_cnt0_model", m_cnt[0], 2);
        check("t2_cnt1_model", m_cnt[1], 1);
        resp(0, 1); check("t2_rid0", int_slaveID, 4'h3); step();
        resp(1, 1); check("t2_rid1", int_slaveID, 4'h5); step();
        resp(0, 1); step();

        // 3: pool exhaustion.
        for (int i = 1; i <= 4; i++) begin
            addr(MW'(i));
            check("t3_alloc", SLAVE_AID, i - 1);
            step();
        end
        addr(4'h5);
        check("t3_full_avalid", SLAVE_AVALID, 0);
        check("t3_full_aready", int_slaveAREADY, 0);
        step();
        SLAVE_ID = 2'd2; SLAVE_VALID = 1'b1; SLAVE_LAST = 1'b1; #1;
        check("t3_freeing_avalid", SLAVE_AVALID, 0);
        step();
        addr(4'h5);
        check("t3_after_avalid", SLAVE_AVALID, 1);
        check("t3_after_aid", SLAVE_AID, 2);
        step();
        for (int t = 0; t < NT; t++) begin
            resp(t, 1);
            step();
        end

        // 4: counter saturation on ID 0x6.
        for (int i = 0; i < CNT_MAX; i++) begin
            addr(4'h6);
            step();
        end
        addr(4'h6);
        check("t4_sat_avalid", SLAVE_AVALID, 0);
        SLAVE_ID = 2'd0; SLAVE_VALID = 1'b1; SLAVE_LAST = 1'b1; #1;
        check("t4_sat_retire_avalid", SLAVE_AVALID, 0);
        step();
        addr(4'h6);
        check("t4_after_avalid", SLAVE_AVALID, 1);
        check("t4_after_aid", SLAVE_AID, 0);
        step();
        for (int i = 0; i < CNT_MAX; i++) begin
            resp(0, 1);
            step();
        end

        // 5: simultaneous increment and retire.
        addr(4'h9); step();
        addr(4'hB); step();
        addr(4'hC); step();
        addr(4'hB);
        SLAVE_ID = 2'd1; SLAVE_VALID = 1'b1; SLAVE_LAST = 1'b1; #1;
        check("t5a_aid", SLAVE_AID, 1);
        step();
        check("t5a_cnt1_model", m_cnt[1], 1);
        resp(1, 1); step();
        addr(4'hD); check("t5a_tag1_free", SLAVE_AID, 1); step();
        addr(4'h9);
        SLAVE_ID = 2'd2; SLAVE_VALID = 1'b1; SLAVE_LAST = 1'b1; #1;
        check("t5b_aid", SLAVE_AID, 0);
        step();
        check("t5b_cnt0_model", m_cnt[0], 2);
        check("t5b_cnt2_model", m_cnt[2], 0);
        addr(4'hE); check("t5b_tag2_free", SLAVE_AID, 2); step();

        // 6: unexpected response on idle tag 3, then reset mid-burst.
        resp(3, 1);
        check("t6_fwd_valid", int_slaveVALID, 1);
        check("t6_fwd_last", int_slaveLAST, 1);
        step();
        idle_inputs();
        check("t6_err_set", unexpRespErr, 1);
        step();
        step();
        check("t6_err_sticky", unexpRespErr, 1);
        addr(4'h2); check("t6_aid", SLAVE_AID, 3); step();
        resp(3, 0); step();
        int_slaveAID    = 4'hE;
        int_slaveAVALID = 1'b1;
        sysReset        = 1'b1;
        #1;
        check("t6_rst_err", unexpRespErr, 0);
        check("t6_rst_aid", SLAVE_AID, 0);
        check("t6_rst_avalid", SLAVE_AVALID, 1);
        reset_model();
        step();
        sysReset = 1'b0;
        idle_inputs();
        step();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            sysReset        = ($urandom_range(0, 199) == 0);
            int_slaveAID    = MW'($urandom_range(0, 5));
            int_slaveAVALID = ($urandom_range(0, 9) < 6);
            SLAVE_AREADY    = ($urandom_range(0, 9) < 7);
            int_slaveREADY  = ($urandom_range(0, 9) < 8);
            SLAVE_VALID     = ($urandom_range(0, 9) < 6);
            SLAVE_LAST      = ($urandom_range(0, 9) < 6);
            busy_list.delete();
            for (int t = 0; t < NT; t++) if (m_cnt[t] > 0) busy_list.push_back(t);
            if (busy_list.size() > 0 && $urandom_range(0, 19) != 0) begin
                pick     = busy_list[$urandom_range(0, busy_list.size() - 1)];
                SLAVE_ID = SW'(pick);
            end else begin
                SLAVE_ID = SW'($urandom_range(0, NT - 1));
            end
            step();
        end
        sysReset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
